// File: rtl/disp_mux_4_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
// Segment patterns are active-low: bit7 = dp, bits6..0 = g..a.
package disp_pkg;

   typedef logic [7:0] seg_t;

   localparam seg_t        SEG_OFF    = 8'hFF;
   localparam logic [3:0]  AN_OFF     = 4'hF;
   localparam int unsigned NUM_DIGITS = 4;

endpackage

// File: rtl/disp_mux_4_decoder_2_4.sv
// 2-to-4 one-hot decoder with enable.
// The output is all zeros when en is low.
module decoder_2_4
   import disp_pkg::*;
(
   input  logic                  en,
   input  logic [1:0]            a,
   output logic [NUM_DIGITS-1:0] bcode
);

   always_comb begin
      bcode = '0;
      if (en) begin
         bcode[a] = 1'b1;
      end
   end

endmodule

// File: rtl/disp_mux_4.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each slot starts with DEAD blanked cycles to suppress ghosting between digits.
module disp_mux_4
   import disp_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 16,
   parameter int unsigned DEAD       = 4
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [7:0] in0,
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic [7:0] in3,
   input  logic [3:0] blank,
   output logic [3:0] an,
   output logic [7:0] sseg,
   output logic [1:0] digit_idx,
   output logic       tick
);

   localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);
   localparam logic [PRESCALE_W-1:0] DEAD_C  = PRESCALE_W'(DEAD);

   logic [PRESCALE_W-1:0] cnt;
   logic                  past_dead;
   logic                  lit;
   seg_t                  cur_seg;
   logic [NUM_DIGITS-1:0] onehot;

   // A zero dead time would make the comparison trivially true.
   if (DEAD == 0) begin : g_no_dead
      assign past_dead = 1'b1;
   end else begin : g_dead
      assign past_dead = (cnt >= DEAD_C);
   end

   assign tick = ~reset & (cnt == '1);
   assign lit  = en & ~blank[digit_idx] & past_dead;

   always_comb begin
      cur_seg = SEG_OFF;
      case (digit_idx)
         2'd0: cur_seg = in0;
         2'd1: cur_seg = in1;
         2'd2: cur_seg = in2;
         2'd3: cur_seg = in3;
         default: cur_seg = SEG_OFF;
      endcase
   end

   decoder_2_4 u_dec (
      .en    (lit),
      .a     (digit_idx),
      .bcode (onehot)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         digit_idx <= '0;
         an        <= AN_OFF;
         sseg      <= SEG_OFF;
      end else begin
         cnt  <= cnt + CNT_ONE;
         an   <= ~onehot;
         sseg <= lit ? cur_seg : SEG_OFF;
         if (tick) begin
            digit_idx <= digit_idx + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_disp_mux_4.sv
// Self-checking bench: two configurations (PRESCALE_W=3/DEAD=2 and PRESCALE_W=2/DEAD=0)
// compared against a time-since-reset arithmetic model of the display.
module tb_disp_mux_4;
   import disp_pkg::*;

   logic       clk = 1'b0;
   logic       reset, en;
   logic [7:0] in0, in1, in2, in3;
   logic [3:0] blank;
   logic [3:0] an_a, an_b;
   logic [7:0] sseg_a, sseg_b;
   logic [1:0] idx_a, idx_b;
   logic       tick_a, tick_b;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned t     = 0;   // non-reset edges since the last reset edge

   always #5 clk = ~clk;

   disp_mux_4 #(.PRESCALE_W(3), .DEAD(2)) dut_a (
      .clk(clk), .reset(reset), .en(en),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3), .blank(blank),
      .an(an_a), .sseg(sseg_a), .digit_idx(idx_a), .tick(tick_a)
   );

   disp_mux_4 #(.PRESCALE_W(2), .DEAD(0)) dut_b (
      .clk(clk), .reset(reset), .en(en),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3), .blank(blank),
      .an(an_b), .sseg(sseg_b), .digit_idx(idx_b), .tick(tick_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   // Outputs produced by the edge that follows time tt (i.e. from the state at tt).
   function automatic logic [11:0] model_out(input int unsigned pw, input int unsigned dead,
                                             input int unsigned tt, input logic e,
                                             input logic [3:0] bl, input logic [7:0] p0,
                                             input logic [7:0] p1, input logic [7:0] p2,
                                             input logic [7:0] p3);
      int unsigned n, c, d;
      logic [7:0]  pats [4];
      logic [3:0]  a_pat;
      n = 1 << pw;
      c = tt % n;
      d = (tt / n) % 4;
      pats[0] = p0; pats[1] = p1; pats[2] = p2; pats[3] = p3;
      if (e && !bl[d] && c >= dead) begin
         a_pat = 4'hF;
         a_pat[d] = 1'b0;
         return {a_pat, pats[d]};
      end
      return 12'hFFF;
   endfunction

   task automatic step();
      logic [11:0] ea, eb;
      logic        r;
      r  = reset;
      ea = model_out(3, 2, t, en, blank, in0, in1, in2, in3);
      eb = model_out(2, 0, t, en, blank, in0, in1, in2, in3);
      @(posedge clk);
      #1;
      if (r) begin
         t  = 0;
         ea = 12'hFFF;
         eb = 12'hFFF;
      end else begin
         t++;
      end
      chk("an_a",   {28'd0, an_a},   {28'd0, ea[11:8]});
      chk("sseg_a", {24'd0, sseg_a}, {24'd0, ea[7:0]});
      chk("idx_a",  {30'd0, idx_a},  (t / 8) % 4);
      chk("tick_a", {31'd0, tick_a}, {31'd0, (!reset && (t % 8) == 7)});
      chk("an_b",   {28'd0, an_b},   {28'd0, eb[11:8]});
      chk("sseg_b", {24'd0, sseg_b}, {24'd0, eb[7:0]});
      chk("idx_b",  {30'd0, idx_b},  (t / 4) % 4);
      chk("tick_b", {31'd0, tick_b}, {31'd0, (!reset && (t % 4) == 3)});
      chk("onecold_a", {31'd0, ($countones(~an_a) <= 1)}, 32'd1);
      chk("onecold_b", {31'd0, ($countones(~an_b) <= 1)}, 32'd1);
   endtask

   task automatic run_until(input int unsigned phase);
      int unsigned guard;
      guard = 0;
      while ((t % 32) != phase && guard < 64) begin
         step();
         guard++;
      end
      chk("run_until", {31'd0, ((t % 32) == phase)}, 32'd1);
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; blank = 4'b0000;
      in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
      step();
      step();
      reset = 1'b0;

      // Reset, first digit, rotation and wrap-around with fixed patterns.
      for (int k = 0; k < 40; k++) begin
         step();
         if (k == 0) chk("e0_an", {28'd0, an_a}, 32'hF);
         if (k == 2) chk("e2_an", {28'd0, an_a}, 32'hE);
         if (k == 2) chk("e2_seg", {24'd0, sseg_a}, 32'hC0);
         if (k == 10) chk("e10_an", {28'd0, an_a}, 32'hD);
         if (k == 10) chk("e10_seg", {24'd0, sseg_a}, 32'hF9);
         if (k == 18) chk("e18_seg", {24'd0, sseg_a}, 32'hA4);
         if (k == 26) chk("e26_an", {28'd0, an_a}, 32'h7);
         if (k == 34) chk("e34_an", {28'd0, an_a}, 32'hE);
      end

      // Digit 2 blanked for a full rotation.
      blank = 4'b0100;
      for (int k = 0; k < 32; k++) step();
      blank = 4'b0000;

      // Drop enable mid-slot 0.
      run_until(3);
      en = 1'b0;
      step();
      chk("en_off_an", {28'd0, an_a}, 32'hF);
      chk("en_off_seg", {24'd0, sseg_a}, 32'hFF);
      en = 1'b1;

      // Reset while digit_idx=2, cnt=5.
      run_until(21);
      chk("pre_rst_idx", {30'd0, idx_a}, 32'd2);
      reset = 1'b1;
      step();
      chk("rst_idx", {30'd0, idx_a}, 32'd0);
      chk("rst_an", {28'd0, an_a}, 32'hF);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) step();
      chk("post_rst_an", {28'd0, an_a}, 32'hE);

      // Randomized traffic.
      for (int k = 0; k < 800; k++) begin
         in0   = 8'($urandom);
         in1   = 8'($urandom);
         in2   = 8'($urandom);
         in3   = 8'($urandom);
         blank = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         en    = ($urandom_range(0, 15) != 0);
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
